reg_read_mux: RTL and testbench

// - Register-file read-port selector for the 8-bit CPU datapath: picks one of NREGS

---
 rtl/reg_read_mux_if.sv | 27 ++
 rtl/reg_read_mux.sv | 78 +++++++
 tb/tb_reg_read_mux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_read_mux_if.sv
// Read-port bundle for reg_read_mux: register-file bus, index and capture
// enable from the decode stage; combinational and registered selections back.
// master = decode-stage driver, slave = the mux itself.
interface reg_read_mux_if #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int IDX_W = 2
);
   logic [NREGS*WIDTH-1:0] regs;
   logic [IDX_W-1:0]       sel;
   logic                   en;
   logic [WIDTH-1:0]       out;
   logic [WIDTH-1:0]       out_q;
   logic [IDX_W-1:0]       sel_q;
   logic                   err;
   logic                   err_q;

   modport master (
      output regs, sel, en,
      input  out, out_q, sel_q, err, err_q
   );

   modport slave (
      input  regs, sel, en,
      output out, out_q, sel_q, err, err_q
   );
endinterface

// File: rtl/reg_read_mux.sv
// reg_read_mux: register-file read-port selector. Picks register `sel` out of
// a flat packed bus (register 0 in the least-significant WIDTH bits), gives it
// back combinationally and as a registered copy captured when `en` is high.
// An out-of-range index yields zero data and raises err.
// Optional build macro: MUX_TRACE_EN -- prints one line per enabled capture
// edge (simulation only); functional behaviour is identical either way.
module reg_read_mux #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int IDX_W = 2
) (
   input logic                 clk,
   input logic                 rst,
   reg_read_mux_if.slave       bus
);

   logic [WIDTH-1:0] out_c;
   logic             hit_c;
   logic             err_c;

   logic [WIDTH-1:0] out_q, out_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic             err_q, err_d;

   // Select the indexed register; no match means the index is out of range.
   always_comb begin
      out_c = '0;
      hit_c = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.sel == IDX_W'(i)) begin
            out_c = bus.regs[WIDTH*i +: WIDTH];
            hit_c = 1'b1;
         end
      end
      err_c = ~hit_c;
   end

   // Next-state for the registered copy: capture on en, otherwise hold.
   always_comb begin
      out_d = out_q;
      sel_d = sel_q;
      err_d = err_q;
      if (bus.en) begin
         out_d = out_c;
         sel_d = bus.sel;
         err_d = err_c;
      end
   end

   // Registered copy; reset wins over capture in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         sel_q <= '0;
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         sel_q <= sel_d;
         err_q <= err_d;
      end
   end

   assign bus.out   = out_c;
   assign bus.err   = err_c;
   assign bus.out_q = out_q;
   assign bus.sel_q = sel_q;
   assign bus.err_q = err_q;

`ifdef MUX_TRACE_EN
   // Trace each enabled capture edge with the value being taken.
   always @(posedge clk) begin
      if (!rst && bus.en)
         $display("MUX : sel=%b val=%0d err=%0b", bus.sel, out_c, err_c);
   end
`else
`endif

endmodule

// File: tb/tb_reg_read_mux.sv
// Bench for reg_read_mux: a 4-register instance and a 3-register instance
// (one unused index) share the stimulus. The driver sets inputs just after a
// rising edge and queues the expected values; a monitor compares them on the
// following falling edge.
module tb_reg_read_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] regs;
   logic [1:0]  sel;
   logic        en;

   int checks   = 0;
   int failures = 0;

   // kind: 0 out, 1 err, 2 out_q, 3 sel_q, 4 err_q (A, NREGS=4)
   //       5 out, 6 err, 7 out_q, 8 err_q        (B, NREGS=3)
   typedef struct {
      string      name;
      int         kind;
      logic [7:0] val;
   } exp_t;
   exp_t exp_q[$];

   reg_read_mux_if #(.WIDTH(8), .NREGS(4), .IDX_W(2)) if_a ();
   reg_read_mux_if #(.WIDTH(8), .NREGS(3), .IDX_W(2)) if_b ();

   assign if_a.regs = regs;
   assign if_a.sel  = sel;
   assign if_a.en   = en;
   assign if_b.regs = regs[23:0];
   assign if_b.sel  = sel;
   assign if_b.en   = en;

   reg_read_mux #(.WIDTH(8), .NREGS(4), .IDX_W(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (if_a.slave)
   );

   reg_read_mux #(.WIDTH(8), .NREGS(3), .IDX_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (if_b.slave)
   );

   // clock
   always #5 clk = ~clk;

   // driver helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string name, input int kind, input logic [7:0] val);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         logic [7:0] act;
         e = exp_q.pop_front();
         case (e.kind)
            0: act = if_a.out;
            1: act = {7'd0, if_a.err};
            2: act = if_a.out_q;
            3: act = {6'd0, if_a.sel_q};
            4: act = {7'd0, if_a.err_q};
            5: act = if_b.out;
            6: act = {7'd0, if_b.err};
            7: act = if_b.out_q;
            default: act = {7'd0, if_b.err_q};
         endcase
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   // stimulus
   initial begin
      logic [7:0] sweep_exp [4];
      sweep_exp[0] = 8'h11;
      sweep_exp[1] = 8'h22;
      sweep_exp[2] = 8'h33;
      sweep_exp[3] = 8'h44;

      rst  = 1'b1;
      en   = 1'b0;
      sel  = 2'd0;
      regs = 32'h44_33_22_11;

      // reset state
      step();
      expect_v("rst_out_q_a", 2, 8'h00);
      expect_v("rst_sel_q_a", 3, 8'h00);
      expect_v("rst_err_q_a", 4, 8'h00);
      expect_v("rst_err_q_b", 8, 8'h00);
      rst = 1'b0;

      // combinational sweep, nothing captured
      for (int i = 0; i < 4; i++) begin
         step();
         sel = 2'(i);
         expect_v("sweep_out_a", 0, sweep_exp[i]);
         expect_v("sweep_err_a", 1, 8'h00);
         expect_v("sweep_out_b", 5, (i < 3) ? sweep_exp[i] : 8'h00);
         expect_v("sweep_err_b", 6, (i < 3) ? 8'h00 : 8'h01);
      end
      expect_v("sweep_hold_out_q_a", 2, 8'h00);

      // capture sel=2 once, then hold with en low
      step();
      sel = 2'd2;
      en  = 1'b1;
      step();
      sel = 2'd0;
      en  = 1'b0;
      expect_v("cap_out_q_a", 2, 8'h33);
      expect_v("cap_sel_q_a", 3, 8'h02);
      expect_v("cap_out_a", 0, 8'h11);
      step();
      sel = 2'd1;
      expect_v("hold_out_q_a", 2, 8'h33);
      expect_v("hold_sel_q_a", 3, 8'h02);
      expect_v("hold_out_b", 7, 8'h33);

      // reset beats capture, then capture resumes
      step();
      rst = 1'b1;
      en  = 1'b1;
      sel = 2'd3;
      step();
      rst = 1'b0;
      expect_v("rstpri_out_q_a", 2, 8'h00);
      expect_v("rstpri_sel_q_a", 3, 8'h00);
      expect_v("rstpri_err_q_a", 4, 8'h00);
      expect_v("rstpri_out_a", 0, 8'h44);
      step();
      en = 1'b0;
      expect_v("resume_out_q_a", 2, 8'h44);
      expect_v("resume_sel_q_a", 3, 8'h03);
      expect_v("oor_out_q_b", 7, 8'h00);
      expect_v("oor_err_q_b", 8, 8'h01);

      // reg0 change seen immediately, captured on the next enabled edge
      step();
      sel  = 2'd0;
      regs = 32'h44_33_22_AA;
      expect_v("regchg_out_a", 0, 8'hAA);
      expect_v("regchg_out_q_a", 2, 8'h44);
      en = 1'b1;
      step();
      en   = 1'b0;
      expect_v("regchg_cap_out_q_a", 2, 8'hAA);
      expect_v("regchg_cap_err_q_b", 8, 8'h00);

      // value present before the edge is the one captured
      regs = 32'h44_33_22_11;
      en   = 1'b1;
      step();
      regs = 32'h44_33_22_55;
      en   = 1'b0;
      expect_v("setup_out_q_a", 2, 8'h11);
      expect_v("setup_out_a", 0, 8'h55);

      // drain: bounded wait for the monitor to consume everything
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d left expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
